// File: rtl/button_conditioner.sv
// Button conditioner: per-channel two-flop synchroniser, debounce FSM and
// auto-repeat generator. It turns raw board buttons into a clean level plus
// one-cycle press/release pulses.
module button_conditioner #(
    parameter int unsigned NUM_BTNS        = 4,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RepW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

    // deb_cnt holds the number of agreeing samples already seen, so a commit
    // happens on the sample that makes DEBOUNCE_CYCLES in a row.
    localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY);
    // A period longer than the delay is clamped to the delay so the reload
    // value can never underflow.
    localparam logic [RepW-1:0] RepReload = (REPEAT_PERIOD <= REPEAT_DELAY) ?
                                            RepW'(REPEAT_DELAY - REPEAT_PERIOD) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } state_e;

    logic [NUM_BTNS-1:0] raw_pol;
    logic [NUM_BTNS-1:0] s1_q, s2_q;

    assign raw_pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Two-flop synchroniser on the polarity-corrected pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_pol;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTNS; g++) begin : gen_chan
        state_e          state_q, state_d;
        logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
        logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            sync;

        assign sync = s2_q[g];

        // Next-state: debounce in both directions, repeat counting while held.
        always_comb begin
            state_d   = state_q;
            deb_cnt_d = deb_cnt_q;
            rep_cnt_d = rep_cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (sync) begin
                        if (DebLast == '0) begin
                            state_d   = StHeld;
                            level_d   = 1'b1;
                            press_d   = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            state_d   = StPressWait;
                            deb_cnt_d = DebW'(1);
                        end
                    end
                end
                StPressWait: begin
                    if (!sync) begin
                        state_d   = StIdle;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DebLast) begin
                        state_d   = StHeld;
                        level_d   = 1'b1;
                        press_d   = 1'b1;
                        deb_cnt_d = '0;
                        rep_cnt_d = '0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DebW'(1);
                    end
                end
                StHeld, StReleaseWait: begin
                    if (sync) begin
                        // A sample back high while in release-wait counts as a
                        // held cycle; rep_cnt resumes from its frozen value.
                        state_d   = StHeld;
                        deb_cnt_d = '0;
                        if (REPEAT_DELAY != 0) begin
                            if (rep_cnt_q + RepW'(1) == RepDelay) begin
                                press_d   = 1'b1;
                                rep_cnt_d = RepReload;
                            end else begin
                                rep_cnt_d = rep_cnt_q + RepW'(1);
                            end
                        end
                    end else if ((state_q == StHeld && DebLast == '0) ||
                                 (state_q == StReleaseWait && deb_cnt_q == DebLast)) begin
                        state_d   = StIdle;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        deb_cnt_d = '0;
                    end else if (state_q == StHeld) begin
                        state_d   = StReleaseWait;
                        deb_cnt_d = DebW'(1);
                    end else begin
                        deb_cnt_d = deb_cnt_q + DebW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= StIdle;
                deb_cnt_q <= '0;
                rep_cnt_q <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                deb_cnt_q <= deb_cnt_d;
                rep_cnt_q <= rep_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance see
// the same (inverted) stimulus and are scored every cycle against a
// window-based reference model; hand sequences check pulse timing.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_raw_n;
    logic [3:0] btn_level, btn_press, btn_release;
    logic [3:0] lvl_n, prs_n, rel_n;

    assign btn_raw_n = ~btn_raw;

    button_conditioner #(
        .NUM_BTNS(4), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    button_conditioner #(
        .NUM_BTNS(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_n (
        .clk(clk), .reset(reset), .btn_raw(btn_raw_n),
        .btn_level(lvl_n), .btn_press(prs_n), .btn_release(rel_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } exp_t;

    typedef struct {
        int e;
        int ch;
        bit rel;
    } ev_t;

    typedef struct {
        logic [3:0] raw;
        int         cycles;
        logic [3:0] lvl;
    } vec_t;

    exp_t sb_q[$];
    ev_t  ev_log[$];
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   got[16];
    int   got_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Gather logged pulse edges for one channel/kind in [lo, hi].
    task automatic collect(input int ch, input bit rel, input int lo, input int hi);
        got_n = 0;
        for (int i = 0; i < 16; i++) got[i] = -1;
        foreach (ev_log[i]) begin
            if (ev_log[i].ch == ch && ev_log[i].rel == rel &&
                ev_log[i].e >= lo && ev_log[i].e <= hi) begin
                if (got_n < 16) got[got_n] = ev_log[i].e;
                got_n++;
            end
        end
    endtask

    // Reference model: level flips when the last D synchronised samples all
    // disagree with it; repeats counted as held samples since the press.
    logic [3:0]   m_s1 = '0, m_s2 = '0, m_lvl = '0;
    logic [D-1:0] m_win [4];
    int           m_hold [4];

    initial begin
        for (int c = 0; c < 4; c++) begin
            m_win[c]  = '0;
            m_hold[c] = 0;
        end
        forever begin
            exp_t x;
            logic [D-1:0] w;
            @(posedge clk);
            edge_n = edge_n + 1;
            x.e   = edge_n;
            x.lvl = '0;
            x.prs = '0;
            x.rel = '0;
            if (reset) begin
                m_s1  = '0;
                m_s2  = '0;
                m_lvl = '0;
                for (int c = 0; c < 4; c++) begin
                    m_win[c]  = '0;
                    m_hold[c] = 0;
                end
            end else begin
                for (int c = 0; c < 4; c++) begin
                    w = {m_win[c][D-2:0], m_s2[c]};
                    x.lvl[c] = m_lvl[c];
                    if (!m_lvl[c] && (&w)) begin
                        x.lvl[c]  = 1'b1;
                        x.prs[c]  = 1'b1;
                        m_hold[c] = 0;
                    end else if (m_lvl[c] && !(|w)) begin
                        x.lvl[c] = 1'b0;
                        x.rel[c] = 1'b1;
                    end else if (m_lvl[c] && m_s2[c]) begin
                        m_hold[c] = m_hold[c] + 1;
                        if (m_hold[c] >= RD && ((m_hold[c] - RD) % RP) == 0) x.prs[c] = 1'b1;
                    end
                    m_win[c] = w;
                end
                m_lvl = x.lvl;
                m_s2  = m_s1;
                m_s1  = btn_raw;
            end
            sb_q.push_back(x);
        end
    end

    // Monitor: pop one expectation per cycle and compare both instances.
    initial begin
        forever begin
            exp_t x;
            ev_t  ev;
            @(negedge clk);
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check($sformatf("cycle%0d_outputs", x.e),
                      32'({btn_level, btn_press, btn_release}), 32'({x.lvl, x.prs, x.rel}));
                check($sformatf("cycle%0d_outputs_active_low", x.e),
                      32'({lvl_n, prs_n, rel_n}), 32'({x.lvl, x.prs, x.rel}));
                for (int c = 0; c < 4; c++) begin
                    if (btn_press[c]) begin
                        ev.e = x.e; ev.ch = c; ev.rel = 1'b0;
                        ev_log.push_back(ev);
                    end
                    if (btn_release[c]) begin
                        ev.e = x.e; ev.ch = c; ev.rel = 1'b1;
                        ev_log.push_back(ev);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   k;
        int   c0;
        int   r;
        vec_t tbl[8];
        logic [4:0] bounce;

        tbl[0] = '{raw: 4'b0000, cycles: 8,  lvl: 4'b0000};
        tbl[1] = '{raw: 4'b0101, cycles: 8,  lvl: 4'b0101};
        tbl[2] = '{raw: 4'b1010, cycles: 8,  lvl: 4'b1010};
        tbl[3] = '{raw: 4'b1111, cycles: 3,  lvl: 4'b1010};
        tbl[4] = '{raw: 4'b1111, cycles: 5,  lvl: 4'b1111};
        tbl[5] = '{raw: 4'b0000, cycles: 2,  lvl: 4'b1111};
        tbl[6] = '{raw: 4'b1111, cycles: 6,  lvl: 4'b1111};
        tbl[7] = '{raw: 4'b0000, cycles: 10, lvl: 4'b0000};

        reset   = 1'b1;
        btn_raw = 4'b0000;
        wait_cyc(3);
        check("reset_outputs", 32'({btn_level, btn_press, btn_release}), 32'h0);
        check("reset_outputs_active_low", 32'({lvl_n, prs_n, rel_n}), 32'h0);
        #1 reset = 1'b0;

        // Clean press on channel 0.
        wait_cyc(2);
        k = edge_n;
        btn_raw[0] = 1'b1;
        wait_cyc(12);
        collect(0, 1'b0, k, edge_n - 1);
        check("clean_press_count", 32'(got_n), 32'd1);
        check("clean_press_edge", 32'(got[0]), 32'(k + 6));
        check("clean_level", 32'(btn_level), 32'h1);
        btn_raw[0] = 1'b0;
        wait_cyc(10);
        check("clean_release_level", 32'(btn_level), 32'h0);

        // Bounce on channel 1 never commits.
        k = edge_n;
        bounce = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            btn_raw[1] = bounce[i];
            wait_cyc(1);
        end
        btn_raw[1] = 1'b0;
        wait_cyc(10);
        collect(1, 1'b0, k, edge_n - 1);
        check("bounce_press_count", 32'(got_n), 32'd0);
        collect(1, 1'b1, k, edge_n - 1);
        check("bounce_release_count", 32'(got_n), 32'd0);

        // Auto-repeat on channel 2: hold 60 cycles, then release.
        k = edge_n;
        btn_raw[2] = 1'b1;
        wait_cyc(60);
        btn_raw[2] = 1'b0;
        wait_cyc(14);
        c0 = k + 6;
        collect(2, 1'b0, k, edge_n - 1);
        check("repeat_press_count", 32'(got_n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("repeat_press_%0d", i), 32'(got[i]),
                  32'(c0 + ((i == 0) ? 0 : 12 + 8 * i)));
        end
        collect(2, 1'b1, k, edge_n - 1);
        check("repeat_release_count", 32'(got_n), 32'd1);
        check("repeat_release_edge", 32'(got[0]), 32'(k + 61 + 5));

        // Release bounce on channel 3 at rep_cnt=10 delays the repeat by 2.
        k = edge_n;
        c0 = k + 6;
        btn_raw[3] = 1'b1;
        wait_cyc(14);
        btn_raw[3] = 1'b0;
        wait_cyc(2);
        btn_raw[3] = 1'b1;
        wait_cyc(24);
        btn_raw[3] = 1'b0;
        wait_cyc(10);
        collect(3, 1'b0, k, edge_n - 1);
        check("relbounce_press_count", 32'(got_n), 32'd3);
        check("relbounce_press_commit", 32'(got[0]), 32'(c0));
        check("relbounce_repeat_1", 32'(got[1]), 32'(c0 + 22));
        check("relbounce_repeat_2", 32'(got[2]), 32'(c0 + 30));
        collect(3, 1'b1, k, edge_n - 1);
        check("relbounce_release_count", 32'(got_n), 32'd1);
        check("relbounce_release_edge", 32'(got[0]), 32'(c0 + 40));

        // Simultaneous press on all four channels.
        k = edge_n;
        btn_raw = 4'b1111;
        wait_cyc(10);
        for (int c = 0; c < 4; c++) begin
            collect(c, 1'b0, k, edge_n - 1);
            check($sformatf("simul_press_count_%0d", c), 32'(got_n), 32'd1);
            check($sformatf("simul_press_edge_%0d", c), 32'(got[0]), 32'(k + 6));
        end
        check("simul_level", 32'(btn_level), 32'hf);

        // Asynchronous reset mid-hold, then a fresh press with buttons held.
        #1 reset = 1'b1;
        #1;
        check("midreset_outputs", 32'({btn_level, btn_press, btn_release}), 32'h0);
        check("midreset_outputs_active_low", 32'({lvl_n, prs_n, rel_n}), 32'h0);
        wait_cyc(2);
        r = edge_n;
        #1 reset = 1'b0;
        wait_cyc(10);
        for (int c = 0; c < 4; c++) begin
            collect(c, 1'b0, r, edge_n - 1);
            check($sformatf("postreset_press_count_%0d", c), 32'(got_n), 32'd1);
            check($sformatf("postreset_press_edge_%0d", c), 32'(got[0]), 32'(r + 6));
        end

        // Level table: mixed channel patterns and short glitches.
        for (int i = 0; i < 8; i++) begin
            btn_raw = tbl[i].raw;
            wait_cyc(tbl[i].cycles);
            check($sformatf("table_%0d_level", i), 32'(btn_level), 32'(tbl[i].lvl));
            check($sformatf("table_%0d_level_active_low", i), 32'(lvl_n), 32'(tbl[i].lvl));
        end

        wait_cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
